// File: rtl/ms_tick_countdown_pkg.sv
// Shared types and constants for the ms tick countdown timer.
// The state encoding here is also used by the debug state output of the top level.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam int MS_PER_SEC_DEFAULT = 1000;
    localparam int CLK_HZ             = 50_000_000;

endpackage

// File: rtl/ms_sec_borrow_counter.sv
// Two-field (seconds / milliseconds) down counter with borrow.
// load has priority over dec. A load starts a fresh second, so ms is zeroed.
// dec never wraps: once both fields are zero, further decrements are ignored.
// is_last flags the final millisecond (sec==0, ms==1), so the caller can see
// that the next decrement reaches zero.
module ms_sec_borrow_counter
    import countdown_pkg::*;
#(
    parameter int MS_PER_SEC = MS_PER_SEC_DEFAULT,
    parameter int SEC_W      = 8,
    parameter int MS_W       = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [SEC_W-1:0] load_val,
    output logic [SEC_W-1:0] sec,
    output logic [MS_W-1:0]  ms,
    output logic             is_last
);

    localparam logic [MS_W-1:0] MS_LAST = MS_W'(MS_PER_SEC - 1);

    // Counter fields: load, then decrement with borrow from seconds into ms.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sec <= '0;
            ms  <= '0;
        end else if (load) begin
            sec <= load_val;
            ms  <= '0;
        end else if (dec) begin
            if (ms != '0) begin
                ms <= ms - MS_W'(1);
            end else if (sec != '0) begin
                ms  <= MS_LAST;
                sec <= sec - SEC_W'(1);
            end
        end
    end

    // Last-millisecond detect, looked at together with dec by the caller.
    always_comb begin
        is_last = (sec == '0) && (ms == MS_W'(1));
    end

endmodule

// File: rtl/ms_tick_countdown.sv
// Countdown timer driven by 1 ms ticks, with second/millisecond remaining outputs.
// It drives the tick generator enable and flags expiry to the game FSM.
// Optional build macro AUTO_RELOAD_EN: on expiry the timer reloads the last
// accepted load value and keeps running, which makes it a periodic interval timer.
// Commands are single-cycle strobes sampled at each clock edge; there is no
// valid/ready handshake. Priority is abort > load > start > pause.
module ms_tick_countdown
    import countdown_pkg::*;
#(
    parameter int MS_PER_SEC = MS_PER_SEC_DEFAULT,
    parameter int SEC_W      = 8,
    parameter int MS_W       = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SEC_W-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             ms_tick,
    output logic             tick_en,
    output logic [SEC_W-1:0] sec_rem,
    output logic [MS_W-1:0]  ms_rem,
    output logic             running,
    output logic             expired,
    output logic             done,
    output logic [1:0]       state_dbg
);

    state_t           state;
    state_t           state_nxt;
    logic             load_ok;
    logic             tick_run;
    logic             expire_evt;
    logic             reload_evt;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_last;
    logic [SEC_W-1:0] cnt_val;
    logic             remain_nz;
    logic             tick_en_d;
    logic             running_d;
    logic             expired_d;
    logic             done_d;

    // A load is only honoured when the timer is not counting.
    assign load_ok    = load && !abort && ((state == IDLE) || (state == EXPIRED));
    // Ticks are consumed only in RUN; abort in the same cycle discards the tick.
    assign tick_run   = (state == RUN) && ms_tick && !abort;
    assign expire_evt = tick_run && cnt_last;
    assign remain_nz  = (sec_rem != '0) || (ms_rem != '0);

`ifdef AUTO_RELOAD_EN
    logic [SEC_W-1:0] shadow;

    // Keep the last accepted load value for reloading on expiry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow <= '0;
        end else if (load_ok) begin
            shadow <= load_val;
        end
    end

    // A zero shadow means nothing to reload; then expiry behaves as one-shot.
    assign reload_evt = expire_evt && (shadow != '0);
    assign cnt_val    = abort ? '0 : (reload_evt ? shadow : load_val);
`else
    assign reload_evt = 1'b0;
    assign cnt_val    = abort ? '0 : load_val;
`endif

    // Abort clears by loading zero; reload replaces the final decrement.
    assign cnt_load = abort || load_ok || reload_evt;
    assign cnt_dec  = tick_run && !reload_evt;

    ms_sec_borrow_counter #(
        .MS_PER_SEC (MS_PER_SEC),
        .SEC_W      (SEC_W),
        .MS_W       (MS_W)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .sec      (sec_rem),
        .ms       (ms_rem),
        .is_last  (cnt_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; expiry outranks a simultaneous pause.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (abort || load) begin
                    state_nxt = IDLE;
                end else if (start && remain_nz) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (expire_evt && !reload_evt) begin
                    state_nxt = EXPIRED;
                end else if (pause) begin
                    state_nxt = PAUSE;
                end
            end
            PAUSE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (start) begin
                    state_nxt = RUN;
                end
            end
            EXPIRED: begin
                if (abort || load) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from the next state, so registered outputs line up with it.
    always_comb begin
        tick_en_d = (state_nxt == RUN);
        running_d = (state_nxt == RUN);
        done_d    = (state_nxt == EXPIRED);
        expired_d = expire_evt;
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_en <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
            expired <= 1'b0;
        end else begin
            tick_en <= tick_en_d;
            running <= running_d;
            done    <= done_d;
            expired <= expired_d;
        end
    end

    // Debug view of the FSM state.
    always_comb begin
        state_dbg = state;
    end

endmodule
